rr_mux4_arbiter: RTL and testbench

- Round-robin arbiter that shares a 4:1 one-bit multiplexer between four requesters.
- Decides which requester owns the mux, drives the select lines (s1,s0), and gates the mux output onto z.
- Enforces a per-owner hold limit so no requester can starve the others.
- Sits directly in front of the MUX4x1 datapath; its sel outputs replace static select stimulus.

---
 rtl/rr_mux4_arbiter.sv | 129 ++++++++++++
 tb/tb_rr_mux4_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter for a shared 4:1 one-bit multiplexer.
// Picks one owner among four requesters, drives the mux select from the
// owner index and gates the mux output onto z. A per-owner hold limit
// forces re-arbitration so no requester can starve the others.

module rr_mux4_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] c,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       z
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state, state_next;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;
    logic [1:0]        last_owner, last_owner_next;
    logic [3:0]        gnt_next;
    logic [1:0]        sel_next;
    logic              busy_next;

    // First requester found scanning start, start+1, ... modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = start;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // State and output registers; reset drops any grant at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            last_owner <= 2'd3;
            gnt        <= 4'b0000;
            sel        <= 2'd0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            hold_cnt   <= hold_cnt_next;
            last_owner <= last_owner_next;
            gnt        <= gnt_next;
            sel        <= sel_next;
            busy       <= busy_next;
        end
    end

    // Arbitration: grant from idle, keep within the hold limit, or hand over
    // directly to the next requester without an idle bubble.
    always_comb begin
        logic [1:0] winner;
        logic       release_now;

        state_next      = state;
        hold_cnt_next   = hold_cnt;
        last_owner_next = last_owner;
        gnt_next        = gnt;
        sel_next        = sel;
        busy_next       = busy;
        winner          = 2'd0;
        release_now     = 1'b0;

        case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    winner          = rr_pick(req, last_owner + 2'd1);
                    state_next      = GRANT;
                    gnt_next        = 4'b0001 << winner;
                    sel_next        = winner;
                    busy_next       = 1'b1;
                    hold_cnt_next   = '0;
                    last_owner_next = winner;
                end
            end
            GRANT: begin
                release_now = !req[sel] || (hold_cnt == HOLD_LAST);
                if (!release_now) begin
                    hold_cnt_next = hold_cnt + HOLD_W'(1);
                end else if (req != 4'b0000) begin
                    winner          = rr_pick(req, sel + 2'd1);
                    gnt_next        = 4'b0001 << winner;
                    sel_next        = winner;
                    busy_next       = 1'b1;
                    hold_cnt_next   = '0;
                    last_owner_next = winner;
                end else begin
                    state_next      = IDLE;
                    gnt_next        = 4'b0000;
                    busy_next       = 1'b0;
                    hold_cnt_next   = '0;
                    last_owner_next = sel;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = 4'b0000;
                busy_next  = 1'b0;
            end
        endcase
    end

    // Gated mux output straight from live data; no added latency.
    always_comb begin
        z = busy ? c[sel] : 1'b0;
    end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed testbench for rr_mux4_arbiter with MAX_HOLD=4.
// Each observation packs {gnt, sel, busy, z} into 8 bits and is compared
// against a hand-computed expected value.

module tb_rr_mux4_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] c;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       z;

    int checks = 0;
    int errors = 0;

    rr_mux4_arbiter #(.MAX_HOLD(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .c    (c),
        .gnt  (gnt),
        .sel  (sel),
        .busy (busy),
        .z    (z)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [3:0] cv);
        rst = r;
        req = rq;
        c   = cv;
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pack(input logic [3:0] g, input logic [1:0] s,
                                        input logic b, input logic zz);
        return {g, s, b, zz};
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got gnt=%b sel=%0d busy=%b z=%b, want gnt=%b sel=%0d busy=%b z=%b",
                     tag, observed[7:4], observed[3:2], observed[1], observed[0],
                     expected[7:4], expected[3:2], expected[1], expected[0]);
        end
    endtask

    initial begin
        int owner;

        applyStimulus(1'b1, 4'b0000, 4'b0000);

        // Reset held with all requests active; z stays low even with c all ones.
        applyStimulus(1'b1, 4'b1111, 4'b1111);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("reset_hold", pack(gnt, sel, busy, z), pack(4'b0000, 2'd0, 1'b0, 1'b0));
        end

        // Release reset under full contention: four cycles per owner, 0..3 then 0.
        applyStimulus(1'b0, 4'b1111, 4'b1111);
        for (int k = 0; k < 20; k++) begin
            step();
            owner = (k / 4) % 4;
            checkOutput("full_contention", pack(gnt, sel, busy, z),
                        pack(4'b0001 << owner, 2'(owner), 1'b1, 1'b1));
        end

        // Sole requester 2 keeps the grant across hold-counter wraps.
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        step();
        applyStimulus(1'b0, 4'b0100, 4'b0000);
        for (int k = 0; k < 11; k++) begin
            step();
            checkOutput("sole_requester", pack(gnt, sel, busy, z), pack(4'b0100, 2'd2, 1'b1, 1'b0));
        end

        // Early release of owner 1 hands over to 3 with no idle bubble.
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        step();
        applyStimulus(1'b0, 4'b0010, 4'b0000);
        step();
        checkOutput("early_grant1", pack(gnt, sel, busy, z), pack(4'b0010, 2'd1, 1'b1, 1'b0));
        applyStimulus(1'b0, 4'b1010, 4'b0000);
        step();
        checkOutput("early_keep1", pack(gnt, sel, busy, z), pack(4'b0010, 2'd1, 1'b1, 1'b0));
        applyStimulus(1'b0, 4'b1000, 4'b0000);
        step();
        checkOutput("early_handover", pack(gnt, sel, busy, z), pack(4'b1000, 2'd3, 1'b1, 1'b0));

        // Datapath gating with c=1010.
        applyStimulus(1'b1, 4'b0000, 4'b1010);
        step();
        applyStimulus(1'b0, 4'b0010, 4'b1010);
        step();
        checkOutput("gate_owner1", pack(gnt, sel, busy, z), pack(4'b0010, 2'd1, 1'b1, 1'b1));
        applyStimulus(1'b0, 4'b0100, 4'b1010);
        step();
        checkOutput("gate_owner2", pack(gnt, sel, busy, z), pack(4'b0100, 2'd2, 1'b1, 1'b0));
        applyStimulus(1'b0, 4'b1000, 4'b1010);
        step();
        checkOutput("gate_owner3", pack(gnt, sel, busy, z), pack(4'b1000, 2'd3, 1'b1, 1'b1));
        applyStimulus(1'b0, 4'b0000, 4'b1010);
        step();
        checkOutput("gate_idle", pack(gnt, sel, busy, z), pack(4'b0000, 2'd3, 1'b0, 1'b0));
        applyStimulus(1'b0, 4'b0000, 4'b1111);
        #1;
        checkOutput("gate_idle_c", pack(gnt, sel, busy, z), pack(4'b0000, 2'd3, 1'b0, 1'b0));

        // Live c change while granted shows up on z without a clock edge.
        applyStimulus(1'b0, 4'b1000, 4'b1111);
        step();
        checkOutput("z_live_hi", pack(gnt, sel, busy, z), pack(4'b1000, 2'd3, 1'b1, 1'b1));
        applyStimulus(1'b0, 4'b1000, 4'b0111);
        #1;
        checkOutput("z_live_lo", pack(gnt, sel, busy, z), pack(4'b1000, 2'd3, 1'b1, 1'b0));

        // Reset mid-grant: owner 2 at hold count 2, then search restarts at 0.
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        step();
        applyStimulus(1'b0, 4'b0100, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            step();
            checkOutput("mid_owner2", pack(gnt, sel, busy, z), pack(4'b0100, 2'd2, 1'b1, 1'b0));
        end
        applyStimulus(1'b1, 4'b1111, 4'b0000);
        step();
        checkOutput("mid_reset", pack(gnt, sel, busy, z), pack(4'b0000, 2'd0, 1'b0, 1'b0));
        applyStimulus(1'b0, 4'b1111, 4'b0000);
        step();
        checkOutput("mid_restart", pack(gnt, sel, busy, z), pack(4'b0001, 2'd0, 1'b1, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
